// File: rtl/wb_result_pipe.sv
// Dual-lane writeback delay pipeline: each issued result is written to the register file
// exactly L cycles after issue; also flags RAW hazards for the RF-stage instruction pair.
module wb_result_pipe #(
  parameter int DEPTH  = 7,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid_even,
  input  logic [0:ADDR_W-1] in_rt_addr_even,
  input  logic [0:DATA_W-1] in_rt_even,
  input  logic [0:2]        in_lat_even,
  input  logic              in_valid_odd,
  input  logic [0:ADDR_W-1] in_rt_addr_odd,
  input  logic [0:DATA_W-1] in_rt_odd,
  input  logic [0:2]        in_lat_odd,
  input  logic [0:31]       instr_even,
  input  logic [0:31]       instr_odd,
  output logic [0:ADDR_W-1] rt_addr_even,
  output logic [0:DATA_W-1] rt_even,
  output logic              reg_write_even,
  output logic [0:ADDR_W-1] rt_addr_odd,
  output logic [0:DATA_W-1] rt_odd,
  output logic              reg_write_odd,
  output logic              raw_stall,
  output logic              err_collision
);

  // Lane 0 = even, lane 1 = odd. Slot 0 is the registered writeback stage.
  logic              v_q [2][DEPTH];
  logic [0:ADDR_W-1] a_q [2][DEPTH];
  logic [0:DATA_W-1] d_q [2][DEPTH];
  logic              err_q;

  logic              in_v [2];
  logic [0:ADDR_W-1] in_a [2];
  logic [0:DATA_W-1] in_d [2];
  logic [2:0]        lat  [2];
  logic [2:0]        le   [2];
  logic              coll [2];
  logic [0:ADDR_W-1] src  [6];

  always_comb begin
    in_v[0] = in_valid_even;
    in_a[0] = in_rt_addr_even;
    in_d[0] = in_rt_even;
    lat[0]  = in_lat_even;
    in_v[1] = in_valid_odd;
    in_a[1] = in_rt_addr_odd;
    in_d[1] = in_rt_odd;
    lat[1]  = in_lat_odd;
    for (int l = 0; l < 2; l++) begin
      le[l]   = (lat[l] == 3'd0) ? 3'd1 : lat[l];
      coll[l] = 1'b0;
      // The value shifting into slot[Le-1] comes from slot[Le]; slot DEPTH-1 receives nothing.
      for (int k = 0; k < DEPTH - 1; k++) begin
        if (in_v[l] && int'(le[l]) == k + 1 && v_q[l][k+1]) coll[l] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < 2; l++) begin
        for (int k = 0; k < DEPTH; k++) begin
          v_q[l][k] <= 1'b0;
          a_q[l][k] <= '0;
          d_q[l][k] <= '0;
        end
      end
      err_q <= 1'b0;
    end else if (flush) begin
      for (int l = 0; l < 2; l++) begin
        for (int k = 0; k < DEPTH; k++) v_q[l][k] <= 1'b0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        for (int k = 0; k < DEPTH - 1; k++) begin
          v_q[l][k] <= v_q[l][k+1];
          a_q[l][k] <= a_q[l][k+1];
          d_q[l][k] <= d_q[l][k+1];
        end
        v_q[l][DEPTH-1] <= 1'b0;
        // Incoming result overrides whatever shifted into its slot.
        for (int k = 0; k < DEPTH; k++) begin
          if (in_v[l] && int'(le[l]) == k + 1) begin
            v_q[l][k] <= 1'b1;
            a_q[l][k] <= in_a[l];
            d_q[l][k] <= in_d[l];
          end
        end
      end
      if (coll[0] || coll[1]) err_q <= 1'b1;
    end
  end

  // Slot 0 and incoming Le=1 results are covered by register-file forwarding.
  always_comb begin
    src[0] = instr_even[25:31];
    src[1] = instr_even[18:24];
    src[2] = instr_even[11:17];
    src[3] = instr_odd[25:31];
    src[4] = instr_odd[18:24];
    src[5] = instr_odd[11:17];
    raw_stall = 1'b0;
    for (int s = 0; s < 6; s++) begin
      for (int l = 0; l < 2; l++) begin
        for (int k = 1; k < DEPTH; k++) begin
          if (v_q[l][k] && a_q[l][k] == src[s]) raw_stall = 1'b1;
        end
        if (in_v[l] && le[l] >= 3'd2 && in_a[l] == src[s]) raw_stall = 1'b1;
      end
    end
  end

  assign reg_write_even = v_q[0][0];
  assign rt_addr_even   = a_q[0][0];
  assign rt_even        = d_q[0][0];
  assign reg_write_odd  = v_q[1][0];
  assign rt_addr_odd    = a_q[1][0];
  assign rt_odd         = d_q[1][0];
  assign err_collision  = err_q;

endmodule

// File: doc/wb_result_pipe.md
Name: wb_result_pipe

Overview:
- Dual-lane (even/odd) result delay pipeline between the execution units and the register-file write port.
- Accepts each issued result with its unit latency and holds it in a per-lane shift register.
- Presents it on the register-file write interface (rt_addr_*, rt_*, reg_write_*) exactly L cycles after issue.
- Computes a combinational RAW stall for the instruction pair in the RF stage against results not yet at writeback.

Parameters:
DEPTH, 7, slots per lane; maximum result latency (1..7; latency field is 3 bits)
ADDR_W, 7, register address width (128 registers)
DATA_W, 128, register data width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  kill all results not yet at writeback
in_valid_even  in  1  even-lane result issued this cycle
in_rt_addr_even  in  [0:6]  destination register
in_rt_even  in  [0:127]  result value
in_lat_even  in  [0:2]  latency L in cycles
in_valid_odd / in_rt_addr_odd / in_rt_odd / in_lat_odd  in  1/[0:6]/[0:127]/[0:2]  odd-lane equivalents
instr_even  in  [0:31]  RF-stage even instr; sources at [25:31], [18:24], [11:17]
instr_odd  in  [0:31]  RF-stage odd instr; same source fields
rt_addr_even  out  [0:6]  WB destination, even
rt_even  out  [0:127]  WB value, even
reg_write_even  out  1  WB write enable, even
rt_addr_odd / rt_odd / reg_write_odd  out  [0:6]/[0:127]/1  odd-lane equivalents
raw_stall  out  1  combinational: RF-stage pair must stall
err_collision  out  1  sticky: slot overwrite occurred

Behaviour:
- Per lane, slots 0..DEPTH-1 hold {valid, addr, data}. Slot 0 is the registered WB output: reg_write_* = slot0.valid, rt_addr_* = slot0.addr, rt_* = slot0.data.
- Effective latency Le = in_lat, except in_lat = 0 is treated as 1.
- Every clock edge (not reset, not flush):
  - slot[k] <= slot[k+1] for k = 0..DEPTH-2; slot[DEPTH-1] <= invalid.
  - If in_valid, then slot[Le-1] <= incoming, overriding the shifted value.
- Timing: a result sampled at edge n has reg_write asserted for exactly one cycle, between edge n+Le-1 and edge n+Le.
  - L=1: visible the cycle right after issue.
  - L=7: visible 6 edges after the sampling edge.
- Collision: in_valid and the value shifting into slot[Le-1] is valid.
  - Incoming result wins; the shifted result is lost.
  - err_collision sets at that edge and holds until reset.
  - Lanes are independent.
- flush sampled high at an edge:
  - All slots of both lanes are invalidated.
  - Incoming results in that cycle are discarded.
  - The slot-0 write in the flush cycle itself still occurs, since it is visible before the edge.
  - Outputs are invalid the following cycle.
  - err_collision is unaffected.
- reset at an edge:
  - All slots are invalid; reg_write_* = 0, rt_addr_* = 0, rt_* = 0, err_collision = 0.
  - Reset overrides flush and in_valid.
  - Reset mid-flight drops every pending result.
- raw_stall (combinational) = 1 if any of the six source addresses matches the addr of any of:
  - a valid slot 1..DEPTH-1 in either lane;
  - a valid incoming result in either lane with Le >= 2.
- raw_stall exclusions:
  - Slot-0 matches and incoming Le=1 matches do not stall; the register file forwards those.
  - raw_stall ignores flush and reset; downstream gates it.
- Both lanes writing the same addr in slot 0: both reg_write signals assert; the register file resolves this with odd winning. No special handling in this block.
- Data passes unmodified; no width conversion.

Test Plan:
- Reset, then idle 10 cycles -> reg_write_even = reg_write_odd = 0, raw_stall = 0, err_collision = 0, rt_* = 0.
- Even issue addr 5, data 128'hA5..A5, L=3 at edge 0 -> reg_write_even = 1, rt_addr_even = 5, data A5..A5 only between edges 2 and 3.
- Odd issue addr 9, L=0 -> treated as L=1: WB valid between edges 0 and 1.
- Timing collision: even issue (addr 3, L=4) at edge 0, then (addr 4, L=3) at edge 1 -> addr 4 written between edges 3 and 4; addr 3 never written; err_collision = 1 from edge 1 onward.
- Stall check: odd pending addr 12 with L=6, and instr_even[18:24] = 12:
  - raw_stall = 1 from issue through the cycle the entry leaves slot 1;
  - raw_stall = 0 while the entry is in slot 0;
  - repeat with L=1 -> raw_stall stays 0.
- Flush: three results pending in both lanes, flush at edge k -> none appear after edge k; the slot-0 write already visible before edge k completes.
- Reset mid-flight -> all results dropped, err_collision cleared.
